traffic_light_ctrl: RTL and testbench
=====================================

# traffic_light_ctrl

Parametrised two-road intersection controller, the next generation of our fixed-timing four-state light. It adds:
- an internal 1 Hz tick prescaler;
- per-phase durations set by parameters;
- all-red clearance intervals;
- a hold input;
- an optional pedestrian walk phase.

It drives the North-South and East-West signal heads directly and sits under the board top level beside the clock and reset logic.

## Interface
Parameters:
- CLK_DIV, 100_000_000: clk cycles per 1-second tick; legal range ≥1.
- CNT_W, 6: width of the phase timer.
- GREEN_SEC, 10: green duration in ticks.
- YELLOW_SEC, 2: yellow duration in ticks.
- ALLRED_SEC, 1: all-red clearance duration in ticks.
- WALK_SEC, 5: pedestrian walk duration in ticks. Used only when PED_EN is defined.
- Rule for GREEN_SEC, YELLOW_SEC, ALLRED_SEC and WALK_SEC: each must be ≥1 and ≤2^CNT_W−1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- hold  in  1  freezes the prescaler and phase timer while high.
- ped_req  in  1  pedestrian button, level or pulse, sampled every clk.
- NS_light  out  3  one-hot light code: red=100, yellow=010, green=001.
- EW_light  out  3  one-hot light code, same encoding as NS_light.
- walk  out  1  pedestrian walk lamp.
- phase  out  3  current state code.
- sec_left  out  CNT_W  ticks remaining in the current state.

## Operation
- Prescaler:
  - Counts 0..CLK_DIV−1 and wraps.
  - tick is high for one cycle when the count equals CLK_DIV−1 and hold=0.
  - With CLK_DIV=1, tick is high every cycle that hold=0.
- States and their phase codes:
  - NSG=0: NS green, EW red.
  - NSY=1: NS yellow, EW red.
  - AR1=2: both red.
  - EWG=3: NS red, EW green.
  - EWY=4: NS red, EW yellow.
  - AR2=5: both red.
  - WALK=6: both red, walk=1.
- Sequence: NSG→NSY→AR1→EWG→EWY→AR2→NSG.
  - With PED_EN, AR2→WALK when ped_pend=1.
  - WALK→NSG.
- Phase timer:
  - Loaded with the new state's duration on every state entry.
  - Decrements on tick.
  - When tick occurs with timer==1, the state advances on that clk edge instead of decrementing.
  - Each state therefore lasts exactly its duration × CLK_DIV cycles, with hold low throughout.
- sec_left equals the timer value: it never shows 0 and is never greater than the duration.
- Outputs are decoded from the registered state; there are no illegal light combinations.
- Codes 7 and the unused state are recovered to NSG with the GREEN_SEC load on the next clk.
- hold=1:
  - The prescaler, timer and state are all frozen.
  - ped_req is still latched.
- Reset while low, mid-operation included:
  - state=NSG, timer=GREEN_SEC, prescaler=0, ped_pend=0.
  - NS_light=001, EW_light=100, walk=0, phase=0, sec_left=GREEN_SEC.

## Timing
- First tick arrives CLK_DIV cycles after the first rising clk edge with rst high.
- A state change is visible on all outputs in the cycle after the advancing edge, with no extra latency.
- ped_req latency:
  - ped_req high on edge n sets ped_pend at edge n; it is visible internally at n+1.
  - A request arriving on the same edge as AR2→(next) is too late to be taken on that edge. It stays pending and is served at the next AR2 exit.
- ped_pend clears on entry to WALK.
- ped_req during WALK is ignored; it is not latched.
- ped_req simultaneous with hold is latched.
- ped_req simultaneous with rst low is discarded.

## Configuration
- PED_EN defined:
  - ped_pend register and WALK state are built.
  - walk is driven as specified above.
- PED_EN undefined:
  - ped_req is unused.
  - walk is tied to 0.
  - WALK is never entered; phase code 6 is recovered to NSG like code 7.
  - The WALK_SEC parameter is ignored.

## Test plan
Bench parameters for all scenarios: CLK_DIV=4, GREEN=3, YELLOW=2, ALLRED=1, WALK=2.

- **Reset:** rst low, then high. Outputs are NS=001, EW=100, phase=0, sec_left=3. NSY is entered after exactly 12 clk cycles.
- **Free run, no ped_req:** phases follow 0,1,2,3,4,5,0. Dwells are 12, 8, 4, 12, 8 and 4 cycles, so one full cycle is 48 cycles. sec_left decrements 3→2→1 in NSG.
- **Pedestrian (PED_EN):** pulse ped_req one cycle during EWG. After AR2, phase=6 and walk=1 for 8 cycles, then NSG. A second pulse during WALK does not cause another WALK.
- **Hold:** assert hold for 20 cycles mid-NSY. phase and sec_left are unchanged throughout. After release, the remaining dwell completes, so total NSY time is 8+20 cycles.
- **Reset mid-operation:** pull rst low during EWY with ped_pend set. Outputs return immediately to the reset values. No WALK occurs in the following cycle.
- **PED_EN undefined:** pulse ped_req repeatedly. walk stays 0 and the 48-cycle sequence is unchanged.

Source files
------------

// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_light_ctrl
//  Purpose  : Two-road intersection light controller with 1 Hz prescaler,
//             parametrised phase durations, all-red clearance and hold.
//  Options  : define PED_EN to build the pedestrian walk phase.
//  Revision : 1.0 - initial release
// ============================================================================
module traffic_light_ctrl #(
   parameter int CLK_DIV    = 100_000_000,
   parameter int CNT_W      = 6,
   parameter int GREEN_SEC  = 10,
   parameter int YELLOW_SEC = 2,
   parameter int ALLRED_SEC = 1,
   parameter int WALK_SEC   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hold,
   input  logic             ped_req,
   output logic [2:0]       NS_light,
   output logic [2:0]       EW_light,
   output logic             walk,
   output logic [2:0]       phase,
   output logic [CNT_W-1:0] sec_left
);

   // Prescaler needs at least one bit even when every cycle is a tick.
   localparam int            c_presc_w   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(CLK_DIV - 1);

   localparam logic [2:0] c_red    = 3'b100;
   localparam logic [2:0] c_yellow = 3'b010;
   localparam logic [2:0] c_green  = 3'b001;

   typedef enum logic [2:0] {
      S_NSG  = 3'd0,
      S_NSY  = 3'd1,
      S_AR1  = 3'd2,
      S_EWG  = 3'd3,
      S_EWY  = 3'd4,
      S_AR2  = 3'd5,
      S_WALK = 3'd6
   } state_t;

   state_t                 r_state;
   logic [CNT_W-1:0]       r_timer;
   logic [c_presc_w-1:0]   r_presc;
   logic [2:0]             r_ns;
   logic [2:0]             r_ew;

   logic                   w_tick;
   logic                   w_legal;
   logic                   w_load;
   state_t                 w_next;

`ifdef PED_EN
   logic                   r_ped_pend;
   logic                   r_walk;
`else
   logic                   w_unused_ped;
   assign w_unused_ped = ped_req;
`endif

   // Duration loaded into the phase timer on entry to a state.
   function automatic logic [CNT_W-1:0] dur(input state_t s);
      case (s)
         S_NSG, S_EWG: dur = CNT_W'(GREEN_SEC);
         S_NSY, S_EWY: dur = CNT_W'(YELLOW_SEC);
         S_AR1, S_AR2: dur = CNT_W'(ALLRED_SEC);
`ifdef PED_EN
         S_WALK:       dur = CNT_W'(WALK_SEC);
`endif
         default:      dur = CNT_W'(GREEN_SEC);
      endcase
   endfunction

   function automatic logic [2:0] ns_of(input state_t s);
      case (s)
         S_NSG:   ns_of = c_green;
         S_NSY:   ns_of = c_yellow;
         default: ns_of = c_red;
      endcase
   endfunction

   function automatic logic [2:0] ew_of(input state_t s);
      case (s)
         S_EWG:   ew_of = c_green;
         S_EWY:   ew_of = c_yellow;
         default: ew_of = c_red;
      endcase
   endfunction

   // Tick generation, state legality and next-state selection.
   always_comb begin
      w_tick  = !hold && (r_presc == c_presc_max);
      w_legal = 1'b0;
      w_load  = 1'b0;
      w_next  = r_state;
      case (r_state)
         S_NSG, S_NSY, S_AR1, S_EWG, S_EWY, S_AR2: w_legal = 1'b1;
`ifdef PED_EN
         S_WALK:                                   w_legal = 1'b1;
`endif
         default:                                  w_legal = 1'b0;
      endcase
      if (!w_legal) begin
         // Unreachable codes fall back to the start of the cycle at once.
         w_load = 1'b1;
         w_next = S_NSG;
      end else if (w_tick && (r_timer == CNT_W'(1))) begin
         w_load = 1'b1;
         case (r_state)
            S_NSG:   w_next = S_NSY;
            S_NSY:   w_next = S_AR1;
            S_AR1:   w_next = S_EWG;
            S_EWG:   w_next = S_EWY;
            S_EWY:   w_next = S_AR2;
`ifdef PED_EN
            S_AR2:   w_next = r_ped_pend ? S_WALK : S_NSG;
`else
            S_AR2:   w_next = S_NSG;
`endif
            default: w_next = S_NSG;
         endcase
      end
   end

   // Prescaler, phase timer, state register and registered light outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_presc    <= '0;
         r_state    <= S_NSG;
         r_timer    <= CNT_W'(GREEN_SEC);
         r_ns       <= c_green;
         r_ew       <= c_red;
`ifdef PED_EN
         r_ped_pend <= 1'b0;
         r_walk     <= 1'b0;
`endif
      end else begin
         if (!hold) begin
            r_presc <= (r_presc == c_presc_max) ? '0 : r_presc + c_presc_w'(1);
         end
         if (w_load) begin
            r_state <= w_next;
            r_timer <= dur(w_next);
            r_ns    <= ns_of(w_next);
            r_ew    <= ew_of(w_next);
         end else if (w_tick) begin
            r_timer <= r_timer - CNT_W'(1);
         end
`ifdef PED_EN
         if (w_load) begin
            r_walk <= (w_next == S_WALK);
         end
         // Entering WALK serves the request; presses during WALK are ignored.
         if (w_load && (w_next == S_WALK)) begin
            r_ped_pend <= 1'b0;
         end else if (ped_req && (r_state != S_WALK)) begin
            r_ped_pend <= 1'b1;
         end
`endif
      end
   end

   assign NS_light = r_ns;
   assign EW_light = r_ew;
   assign phase    = r_state;
   assign sec_left = r_timer;
`ifdef PED_EN
   assign walk     = r_walk;
`else
   assign walk     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_light_ctrl
//  Purpose  : Directed self-checking bench for traffic_light_ctrl
//             (CLK_DIV=4, GREEN=3, YELLOW=2, ALLRED=1, WALK=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_light_ctrl;

`ifdef PED_EN
   localparam bit c_toggle_ped = 1'b0;
`else
   localparam bit c_toggle_ped = 1'b1;
`endif

   logic       clk;
   logic       rst;
   logic       hold;
   logic       ped_req;
   logic [2:0] NS_light;
   logic [2:0] EW_light;
   logic       walk;
   logic [2:0] phase;
   logic [5:0] sec_left;

   int n_tests = 0;
   int n_fail  = 0;

   traffic_light_ctrl #(
      .CLK_DIV    (4),
      .CNT_W      (6),
      .GREEN_SEC  (3),
      .YELLOW_SEC (2),
      .ALLRED_SEC (1),
      .WALK_SEC   (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .hold     (hold),
      .ped_req  (ped_req),
      .NS_light (NS_light),
      .EW_light (EW_light),
      .walk     (walk),
      .phase    (phase),
      .sec_left (sec_left)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Expected light heads for a phase code.
   function automatic logic [2:0] exp_ns(input logic [2:0] p);
      case (p)
         3'd0:    exp_ns = 3'b001;
         3'd1:    exp_ns = 3'b010;
         default: exp_ns = 3'b100;
      endcase
   endfunction

   function automatic logic [2:0] exp_ew(input logic [2:0] p);
      case (p)
         3'd3:    exp_ew = 3'b001;
         3'd4:    exp_ew = 3'b010;
         default: exp_ew = 3'b100;
      endcase
   endfunction

   // Count clk edges until phase changes (bounded), then check the new state.
   task automatic measure(input string tag, input int exp_dwell,
                          input logic [2:0] exp_next, input bit toggle);
      int          n;
      logic [2:0]  p0;
      p0 = phase;
      n  = 0;
      while ((phase === p0) && (n < 200)) begin
         if (toggle) ped_req = ~ped_req;
         @(negedge clk);
         n++;
      end
      ped_req = 1'b0;
      chk({tag, "_dwell"}, n, exp_dwell);
      chk({tag, "_phase"}, {29'd0, phase}, {29'd0, exp_next});
      chk({tag, "_ns"}, {29'd0, NS_light}, {29'd0, exp_ns(exp_next)});
      chk({tag, "_ew"}, {29'd0, EW_light}, {29'd0, exp_ew(exp_next)});
      chk({tag, "_walk"}, {31'd0, walk}, {31'd0, (exp_next == 3'd6)});
   endtask

   task automatic full_cycle(input string tag, input bit toggle);
      measure({tag, "_nsg"}, 12, 3'd1, toggle);
      measure({tag, "_nsy"},  8, 3'd2, toggle);
      measure({tag, "_ar1"},  4, 3'd3, toggle);
      measure({tag, "_ewg"}, 12, 3'd4, toggle);
      measure({tag, "_ewy"},  8, 3'd5, toggle);
      measure({tag, "_ar2"},  4, 3'd0, toggle);
   endtask

   initial begin
      rst     = 1'b0;
      hold    = 1'b0;
      ped_req = 1'b0;

      // Reset values while rst is held low.
      cyc(3);
      chk("rst_ns",    {29'd0, NS_light}, 32'd1);
      chk("rst_ew",    {29'd0, EW_light}, 32'd4);
      chk("rst_phase", {29'd0, phase},    32'd0);
      chk("rst_sec",   {26'd0, sec_left}, 32'd3);
      chk("rst_walk",  {31'd0, walk},     32'd0);
      // A press during reset must be discarded.
      ped_req = 1'b1;
      cyc(1);
      ped_req = 1'b0;
      rst = 1'b1;

      // NSG countdown 3 -> 2 -> 1, NSY entered on edge 12.
      cyc(1);
      chk("nsg_e1_phase", {29'd0, phase},    32'd0);
      chk("nsg_e1_sec",   {26'd0, sec_left}, 32'd3);
      cyc(3);
      chk("nsg_e4_sec",   {26'd0, sec_left}, 32'd2);
      cyc(4);
      chk("nsg_e8_sec",   {26'd0, sec_left}, 32'd1);
      cyc(3);
      chk("nsg_e11_phase", {29'd0, phase},   32'd0);
      cyc(1);
      chk("nsy_e12_phase", {29'd0, phase},    32'd1);
      chk("nsy_e12_sec",   {26'd0, sec_left}, 32'd2);
      chk("nsy_e12_ns",    {29'd0, NS_light}, 32'd2);
      chk("nsy_e12_ew",    {29'd0, EW_light}, 32'd4);

      measure("fr_nsy", 8, 3'd2, 1'b0);
      measure("fr_ar1", 4, 3'd3, 1'b0);
      // One-cycle press during EWG.
      ped_req = 1'b1;
      cyc(1);
      ped_req = 1'b0;
      measure("fr_ewg", 11, 3'd4, 1'b0);
      measure("fr_ewy",  8, 3'd5, 1'b0);
`ifdef PED_EN
      measure("fr_ar2", 4, 3'd6, 1'b0);
      chk("walk_sec", {26'd0, sec_left}, 32'd2);
      // Press during WALK must not be latched.
      ped_req = 1'b1;
      cyc(1);
      ped_req = 1'b0;
      measure("walk", 7, 3'd0, 1'b0);
`else
      measure("fr_ar2", 4, 3'd0, 1'b0);
`endif
      full_cycle("cyc", c_toggle_ped);

      // Hold for 20 cycles three edges into NSY.
      measure("h_nsg", 12, 3'd1, 1'b0);
      cyc(3);
      chk("h_pre_sec", {26'd0, sec_left}, 32'd2);
      hold = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("hold_phase", {29'd0, phase},    32'd1);
         chk("hold_sec",   {26'd0, sec_left}, 32'd2);
      end
      hold = 1'b0;
      measure("h_nsy", 5, 3'd2, 1'b0);

      // Set a pending request in EWG, then reset during EWY.
      measure("r_ar1", 4, 3'd3, 1'b0);
      ped_req = 1'b1;
      cyc(1);
      ped_req = 1'b0;
      measure("r_ewg", 11, 3'd4, 1'b0);
      cyc(2);
      rst = 1'b0;
      #1;
      chk("mrst_ns",    {29'd0, NS_light}, 32'd1);
      chk("mrst_ew",    {29'd0, EW_light}, 32'd4);
      chk("mrst_phase", {29'd0, phase},    32'd0);
      chk("mrst_sec",   {26'd0, sec_left}, 32'd3);
      chk("mrst_walk",  {31'd0, walk},     32'd0);
      cyc(2);
      rst = 1'b1;
      // The request pending before reset must be gone: no WALK after AR2.
      full_cycle("post", c_toggle_ped);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
